echo_detector: RTL
==================

ECHO_DETECTOR -- requirements
Module: echo_detector

Interface
REQ-001 Parameter THRESH, default 20: 8-bit detection threshold; a sample is "above" when strictly greater than THRESH.
REQ-002 Parameter MIN_WIDTH, default 2: minimum accepted pulse width in samples.
REQ-003 Parameter MAX_WIDTH, default 12: maximum accepted pulse width in samples, 1..14.
REQ-004 Parameter TIMEOUT, default 1000: cycle count after which detection stops.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 reset  in  1  synchronous, active-high; also marks time zero (shot start).
REQ-007 signal  in  8  unsigned echo sample stream, one sample per clk.
REQ-008 valid  out  1  one-cycle strobe; tof/peak/width valid while high.
REQ-009 tof  out  32  cnt value of the peak sample of the reported pulse.
REQ-010 peak  out  8  maximum sample value of the reported pulse.
REQ-011 width  out  4  number of above-threshold samples in the reported pulse.
REQ-012 pulse_cnt  out  4  number of reported pulses since reset, saturating at 15.
REQ-013 timeout  out  1  sticky; high when TIMEOUT reached with zero pulses reported.
REQ-014 busy  out  1  high in ARMED and PULSE states.

Function
REQ-015 Free-running 32-bit cnt SHALL be 0 in the first cycle after reset deasserts and increment by 1 each cycle; signal sampled at edge with cnt=k belongs to time k.
REQ-016 FSM states: ARMED, PULSE, HALT; after reset the FSM SHALL be in ARMED.
REQ-017 ARMED: sample above THRESH -> PULSE, width_acc=1, peak_acc=sample, pos_acc=cnt.
REQ-018 PULSE: sample above -> width_acc increments, saturating at MAX_WIDTH+1; if sample strictly greater than peak_acc, peak_acc=sample and pos_acc=cnt (first maximum kept on ties).
REQ-019 PULSE: sample not above -> ARMED; if MIN_WIDTH <= width_acc <= MAX_WIDTH, valid SHALL be high in the next cycle with tof=pos_acc, peak=peak_acc, width=width_acc, and pulse_cnt SHALL increment in that cycle.
REQ-020 Pulses outside [MIN_WIDTH, MAX_WIDTH] SHALL be discarded silently: no valid, no pulse_cnt change.
REQ-021 tof/peak/width SHALL hold their last reported values between strobes.
REQ-022 ARMED with cnt >= TIMEOUT: -> HALT; timeout=1 if pulse_cnt==0, else stays 0.
REQ-023 PULSE in progress when cnt reaches TIMEOUT SHALL complete and be judged normally; HALT is entered from ARMED afterwards.
REQ-024 HALT SHALL ignore signal and remain until reset; cnt saturates at 2^32-1 and does not wrap.
REQ-025 A pulse ending and a new above sample in back-to-back cycles SHALL both be detected (gap of one below-threshold sample suffices).

Reset
REQ-026 Reset SHALL set valid=0, tof=0, peak=0, width=0, pulse_cnt=0, timeout=0, cnt=0, state ARMED, accumulators 0.
REQ-027 Reset asserted mid-pulse SHALL abort the pulse with no valid strobe; reset dominates all other events in the same cycle.

Structure
REQ-028 Parameter defaults and FSM state encodings SHALL live in shared package rangefinder_pkg.
REQ-029 One sub-module, echo_peak_track (running max, position and width accumulator with clear/enable), is natural; FSM and cnt stay in echo_detector.
REQ-030 RTL SHALL be synthesizable and use no clock other than clk.

Verification
REQ-031 Reset released; signal 0 except cnt 100..104 = 5,48,99,48,5 -> one valid at cnt=105 with tof=102, peak=99, width=3, pulse_cnt=1.
REQ-032 Single sample 200 at cnt=50, else 0 -> no valid (width 1 < MIN_WIDTH); pulse_cnt=0.
REQ-033 Signal 60 for cnt 10..29 (20 samples) -> no valid; a following 3-sample pulse 30,90,30 at cnt 40..42 -> valid with tof=41, peak=90, width=3.
REQ-034 Plateau 80,80,80 at cnt 10..12 -> tof=10 (first max); then 50,70 at cnt 14..15 -> second valid, pulse_cnt=2.
REQ-035 Signal all 0, TIMEOUT=1000 -> timeout rises when cnt=1000, busy falls; later pulses ignored until reset.
REQ-036 Reset at cnt 101 inside pulse of REQ-031 -> no valid; all outputs 0; cnt restarts at 0.

Source files
------------

// File: rtl/rangefinder_pkg.sv
// Shared definitions for the rangefinder echo path: data widths, default
// detector tuning and the detector FSM state encoding.
package rangefinder_pkg;

  localparam int DATA_W  = 8;
  localparam int WIDTH_W = 4;
  localparam int CNT_W   = 32;
  localparam int PCNT_W  = 4;

  localparam int THRESH_DEF    = 20;
  localparam int MIN_WIDTH_DEF = 2;
  localparam int MAX_WIDTH_DEF = 12;
  localparam int TIMEOUT_DEF   = 1000;

  typedef enum logic [1:0] {
    ST_ARMED = 2'd0,
    ST_PULSE = 2'd1,
    ST_HALT  = 2'd2
  } det_state_t;

endpackage

// File: rtl/echo_peak_track.sv
// Running accumulator for one echo pulse: width in samples, maximum sample
// value and the time of the first sample that reached that maximum.
module echo_peak_track
  import rangefinder_pkg::*;
#(
  parameter int MAX_WIDTH = MAX_WIDTH_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               update,
  input  logic [DATA_W-1:0]  sample,
  input  logic [CNT_W-1:0]   cnt,
  output logic [DATA_W-1:0]  peak_acc,
  output logic [CNT_W-1:0]   pos_acc,
  output logic [WIDTH_W-1:0] width_acc
);

  // One past the accepted maximum is enough to mark a pulse as too long.
  localparam logic [WIDTH_W-1:0] WIDTH_CAP = WIDTH_W'(MAX_WIDTH + 1);

  function automatic logic [WIDTH_W-1:0] width_sat_inc(input logic [WIDTH_W-1:0] w);
    if (w >= WIDTH_CAP) return WIDTH_CAP;
    return w + WIDTH_W'(1);
  endfunction

  // Start loads the first above sample; update extends the pulse, keeping the first maximum on ties.
  always_ff @(posedge clk) begin
    if (reset) begin
      peak_acc  <= '0;
      pos_acc   <= '0;
      width_acc <= '0;
    end else if (start) begin
      peak_acc  <= sample;
      pos_acc   <= cnt;
      width_acc <= WIDTH_W'(1);
    end else if (update) begin
      width_acc <= width_sat_inc(width_acc);
      if (sample > peak_acc) begin
        peak_acc <= sample;
        pos_acc  <= cnt;
      end
    end
  end

endmodule

// File: rtl/echo_detector.sv
// Echo detector: finds above-threshold pulses in a sample stream after a shot
// (reset), reports peak value, peak time and width of each accepted pulse, and
// stops listening once the timeout count has elapsed.
module echo_detector
  import rangefinder_pkg::*;
#(
  parameter int THRESH    = THRESH_DEF,
  parameter int MIN_WIDTH = MIN_WIDTH_DEF,
  parameter int MAX_WIDTH = MAX_WIDTH_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DATA_W-1:0]  signal,
  output logic               valid,
  output logic [CNT_W-1:0]   tof,
  output logic [DATA_W-1:0]  peak,
  output logic [WIDTH_W-1:0] width,
  output logic [PCNT_W-1:0]  pulse_cnt,
  output logic               timeout,
  output logic               busy
);

  localparam logic [DATA_W-1:0]  THR_V   = DATA_W'(THRESH);
  localparam logic [WIDTH_W-1:0] MIN_W_V = WIDTH_W'(MIN_WIDTH);
  localparam logic [WIDTH_W-1:0] MAX_W_V = WIDTH_W'(MAX_WIDTH);
  localparam logic [CNT_W-1:0]   TMO_V   = CNT_W'(TIMEOUT);

  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
    if (c == '1) return c;
    return c + CNT_W'(1);
  endfunction

  function automatic logic [PCNT_W-1:0] pcnt_sat_inc(input logic [PCNT_W-1:0] p);
    if (p == '1) return p;
    return p + PCNT_W'(1);
  endfunction

  det_state_t         state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               above_p0;
  logic               timed_out_p0;
  logic               trk_start_p0;
  logic               trk_update_p0;
  logic               vld_p0;
  logic               halt_enter_p0;
  logic [DATA_W-1:0]  peak_acc;
  logic [CNT_W-1:0]   pos_acc;
  logic [WIDTH_W-1:0] width_acc;

  assign above_p0     = (signal > THR_V);
  assign timed_out_p0 = (cnt >= TMO_V);
  assign busy         = (state != ST_HALT);

  echo_peak_track #(
    .MAX_WIDTH (MAX_WIDTH)
  ) u_track (
    .clk       (clk),
    .reset     (reset),
    .start     (trk_start_p0),
    .update    (trk_update_p0),
    .sample    (signal),
    .cnt       (cnt),
    .peak_acc  (peak_acc),
    .pos_acc   (pos_acc),
    .width_acc (width_acc)
  );

  // Shot-relative time base; sticks at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) cnt <= '0;
    else       cnt <= cnt_sat_inc(cnt);
  end

  // Detector state register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_ARMED;
    else       state <= state_nxt;
  end

  // Next state, tracker control and pulse acceptance. Timeout is only honoured
  // from ARMED so a pulse straddling the deadline is still judged.
  always_comb begin
    state_nxt     = state;
    trk_start_p0  = 1'b0;
    trk_update_p0 = 1'b0;
    vld_p0        = 1'b0;
    halt_enter_p0 = 1'b0;
    case (state)
      ST_ARMED: begin
        if (timed_out_p0) begin
          state_nxt     = ST_HALT;
          halt_enter_p0 = 1'b1;
        end else if (above_p0) begin
          state_nxt    = ST_PULSE;
          trk_start_p0 = 1'b1;
        end
      end
      ST_PULSE: begin
        if (above_p0) begin
          trk_update_p0 = 1'b1;
        end else begin
          state_nxt = ST_ARMED;
          if ((width_acc >= MIN_W_V) && (width_acc <= MAX_W_V)) vld_p0 = 1'b1;
        end
      end
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_ARMED;
    endcase
  end

  // ---- stage p0 -> outputs: register the report, hold results between strobes ----
  always_ff @(posedge clk) begin
    if (reset) begin
      valid     <= 1'b0;
      tof       <= '0;
      peak      <= '0;
      width     <= '0;
      pulse_cnt <= '0;
      timeout   <= 1'b0;
    end else begin
      valid <= vld_p0;
      if (vld_p0) begin
        tof       <= pos_acc;
        peak      <= peak_acc;
        width     <= width_acc;
        pulse_cnt <= pcnt_sat_inc(pulse_cnt);
      end
      if (halt_enter_p0 && (pulse_cnt == '0)) timeout <= 1'b1;
    end
  end

endmodule
